// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared op codes, FSM states and constants for the HI/LO multiply/divide unit
package mult_div_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_LO    = 32'hFFFFFFFF;

endpackage

// File: rtl/mult_div_sign_fix.sv
// rtl/mult_div_sign_fix.sv - operand magnitude conditioning and two's-complement result correction
module mult_div_sign_fix
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic [WIDTH-1:0]   abs_a_o,
    output logic [WIDTH-1:0]   abs_b_o,
    output logic               neg_a_o,
    output logic               neg_b_o,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic               neg_prod_i,
    output logic [2*WIDTH-1:0] prod_o,
    input  logic [WIDTH-1:0]   quot_i,
    input  logic               neg_quot_i,
    output logic [WIDTH-1:0]   quot_o,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic               neg_rem_i,
    output logic [WIDTH-1:0]   rem_o
);

    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    assign neg_a_o = signed_i & a_i[WIDTH-1];
    assign neg_b_o = signed_i & b_i[WIDTH-1];
    assign abs_a_o = neg_a_o ? (~a_i + 1'b1) : a_i;
    assign abs_b_o = neg_b_o ? (~b_i + 1'b1) : b_i;

    assign prod_o  = neg_prod_i ? (~prod_i + 1'b1) : prod_i;
    assign quot_o  = neg_quot_i ? (~quot_i + 1'b1) : quot_i;
    assign rem_o   = neg_rem_i  ? (~rem_i  + 1'b1) : rem_i;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit; MULT_DIV_FAST_MULT_EN selects a single-cycle multiply
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rs_q, rs_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               neg_a, neg_b;
    logic               signed_op;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, rem_sh, trial;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);

`ifdef MULT_DIV_FAST_MULT_EN
    assign prod_mag = is_div_q ? acc_q
                               : ({{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q});
`else
    assign prod_mag = acc_q;
`endif

    mult_div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a_i        (rs),
        .b_i        (rt),
        .signed_i   (signed_op),
        .abs_a_o    (abs_a),
        .abs_b_o    (abs_b),
        .neg_a_o    (neg_a),
        .neg_b_o    (neg_b),
        .prod_i     (prod_mag),
        .neg_prod_i (neg_lo_q),
        .prod_o     (prod_fix),
        .quot_i     (acc_q[WIDTH-1:0]),
        .neg_quot_i (neg_lo_q),
        .quot_o     (quot_fix),
        .rem_i      (acc_q[2*WIDTH-1:WIDTH]),
        .neg_rem_i  (neg_hi_q),
        .rem_o      (rem_fix)
    );

    // Multiply keeps {partial product, remaining multiplier bits} in acc; divide keeps {remainder, dividend/quotient}.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, b_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rs_d     = rs_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            a_d      = abs_a;
                            b_d      = abs_b;
                            acc_d    = {{WIDTH{1'b0}}, abs_b};
                            is_div_d = 1'b0;
                            div0_d   = 1'b0;
                            neg_lo_d = neg_a ^ neg_b;
                            neg_hi_d = 1'b0;
                            cnt_d    = '0;
`ifdef MULT_DIV_FAST_MULT_EN
                            state_d  = FIX;
`else
                            state_d  = RUN;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d      = abs_a;
                            b_d      = abs_b;
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            rs_d     = rs;
                            is_div_d = 1'b1;
                            div0_d   = (rt == '0);
                            neg_lo_d = neg_a ^ neg_b;
                            neg_hi_d = neg_a;
                            cnt_d    = '0;
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (!trial[WIDTH]) begin
                        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else if (acc_q[0]) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q && div0_q) begin
                    hi_d = rs_q;
                    lo_d = WIDTH'(DIV0_LO);
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rs_q     <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rs_q     <= rs_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed and randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;
    import mult_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'h0) begin
                    m_hi = a;
                    m_lo = 32'hFFFFFFFF;
                end else if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Called mid-cycle; the start pulse lands in whatever cycle we are in (including a done cycle).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj, input string tag);
        logic [31:0] old_h, old_l;
        int n, exp_lat;
        old_h = m_hi;
        old_l = m_lo;
        model(o, a, b);
        exp_lat = 33;
`ifdef MULT_DIV_FAST_MULT_EN
        if (o < 3'd2) exp_lat = 1;
`endif
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_on"}, 64'(busy), 64'd1);
        chk({tag, "_done_low"}, 64'(done), 64'd0);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            chk({tag, "_hold"}, {hi, lo}, {old_h, old_l});
            if (n == inj) begin
                start = 1'b1; op = OP_DIVU; rs = $urandom; rt = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    endtask

    logic [2:0]  t_op [7] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3};
    logic [31:0] t_a  [7] = '{32'hFFFFEDCA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'd100, 32'h80000000, 32'h00001234};
    logic [31:0] t_b  [7] = '{32'hFE8BACDE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                              32'd7, 32'hFFFFFFFF, 32'h0};
    logic [31:0] t_hi [7] = '{32'h0000001A, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF,
                              32'd2, 32'h0, 32'h00001234};
    logic [31:0] t_lo [7] = '{32'h7C61ED2C, 32'h00000001, 32'h1, 32'hFFFFFFFD,
                              32'd14, 32'h80000000, 32'hFFFFFFFF};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b, sh, sl;
        logic        saw_done;

        reset = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], -1, $sformatf("dir%0d", i));
            chk($sformatf("dir%0d_const", i), {hi, lo}, {t_hi[i], t_lo[i]});
        end
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);

        start = 1'b1; op = OP_MTHI; rs = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; model(3'd4, 32'hDEADBEEF, 32'h0);
        chk("mthi_hi", 64'(hi), 64'(m_hi));
        chk("mthi_busy", {63'd0, busy, done}, 64'd0);
        start = 1'b1; op = OP_MTLO; rs = 32'h0BADF00D;
        @(posedge clk); #1;
        start = 1'b0; model(3'd5, 32'h0BADF00D, 32'h0);
        chk("mtlo_hilo", {hi, lo}, {32'hDEADBEEF, 32'h0BADF00D});
        chk("mtlo_busy", {63'd0, busy, done}, 64'd0);

        start = 1'b1; op = 3'd6; rs = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        chk("unknown_op_hilo", {hi, lo}, {m_hi, m_lo});
        chk("unknown_op_busy", {63'd0, busy, done}, 64'd0);

        run_op(OP_MULT, $urandom, $urandom, 10, "ignored_start");

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op(o, a, b, -1, "rand");
        end

        @(posedge clk); #1;
        start = 1'b1; op = OP_DIV; rs = $urandom; rt = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        saw_done = 1'b0;
        sh = hi; sl = lo;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        chk("abort_quiet", {31'd0, saw_done, sh, sl}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
